// File: rtl/dmac_8257.sv
// Two-channel uPD8257-style DMA controller (channels 2 and 3) feeding the CRTC row-buffer DMA.
// Channel 2 supplies VRAM read addresses; channel 3 holds the autoload values.
module dmac_8257 #(
  parameter int unsigned XFER_CYC = 2,
  parameter logic [3:0]  IO_BASE  = 4'h4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [3:0]  io_adr,
  input  logic [7:0]  io_din,
  output logic [7:0]  io_dout,
  input  logic        dreq,
  output logic        dack,
  output logic        z80_busrq_n,
  input  logic        z80_busak_n,
  output logic [15:0] ram_adr,
  output logic        tc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACT, S_REL} state_t;

  localparam int unsigned    PW      = (XFER_CYC > 1) ? $clog2(XFER_CYC) : 1;
  localparam logic [PW-1:0]  PH_LAST = PW'(XFER_CYC - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [15:0]   adr2_q, adr2_d, cnt2_q, cnt2_d, adr3_q, adr3_d, cnt3_q, cnt3_d;
  logic          en_q, en_d, tcs_q, tcs_d, al_q, al_d, fl_q, fl_d;
  logic          tc2_q, tc2_d, upd_q, upd_d, dack_q, dack_d, busrq_n_q, busrq_n_d;

  logic [3:0] off;
  logic       in_rng, wr, rd, acc, byte_done, reload;

  assign off       = io_adr - IO_BASE;
  assign in_rng    = off < 4'd5;
  assign wr        = io_we && in_rng;
  assign rd        = io_re && in_rng;
  assign acc       = (io_we || io_re) && in_rng && (off < 4'd4);
  assign byte_done = (state_q == S_ACT) && dreq && en_q && (phase_q == PH_LAST);
  assign tc        = byte_done && (cnt2_q[13:0] == 14'd0);
  assign reload    = tc && al_q;

  assign dack        = dack_q;
  assign z80_busrq_n = busrq_n_q;
  assign ram_adr     = adr2_q;

  function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi,
                                           input logic [7:0] b);
    return hi ? {b, v[7:0]} : {v[15:8], b};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (dreq && en_q) state_d = S_REQ;
      S_REQ: begin
        if (!dreq)             state_d = S_IDLE;
        else if (!z80_busak_n) state_d = S_ACT;
      end
      S_ACT:  if (!dreq || !en_q) state_d = S_REL;
      S_REL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they track state_q exactly.
  always_comb begin
    dack_d    = (state_d == S_ACT);
    busrq_n_d = !((state_d == S_REQ) || (state_d == S_ACT));
    phase_d   = '0;
    if ((state_q == S_ACT) && dreq && en_q)
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
  end

  always_comb begin
    adr2_d = adr2_q;
    cnt2_d = cnt2_q;
    adr3_d = adr3_q;
    cnt3_d = cnt3_q;
    en_d   = en_q;
    tcs_d  = tcs_q;
    al_d   = al_q;
    fl_d   = fl_q;
    tc2_d  = tc2_q;
    upd_d  = upd_q;
    if (byte_done) begin
      upd_d = reload;
      if (reload) begin
        adr2_d = adr3_q;
        cnt2_d = cnt3_q;
      end else begin
        adr2_d = adr2_q + 16'd1;
        cnt2_d = {cnt2_q[15:14], cnt2_q[13:0] - 14'd1};
      end
    end
    if (tc && !al_q && tcs_q) en_d = 1'b0;
    if (rd && (off == 4'd4)) tc2_d = 1'b0;
    if (tc) tc2_d = 1'b1;
    if (acc) fl_d = !fl_q;
    // CPU writes come last so they override any same-cycle increment or reload.
    if (wr) begin
      unique case (off)
        4'd0: begin
          adr2_d = put_byte(adr2_q, fl_q, io_din);
          if (al_q) adr3_d = put_byte(adr3_q, fl_q, io_din);
        end
        4'd1: begin
          cnt2_d = put_byte(cnt2_q, fl_q, io_din);
          if (al_q) cnt3_d = put_byte(cnt3_q, fl_q, io_din);
        end
        4'd2: adr3_d = put_byte(adr3_q, fl_q, io_din);
        4'd3: cnt3_d = put_byte(cnt3_q, fl_q, io_din);
        4'd4: begin
          en_d  = io_din[2];
          tcs_d = io_din[6];
          al_d  = io_din[7];
          fl_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= '0;
      adr2_q    <= '0;
      cnt2_q    <= '0;
      adr3_q    <= '0;
      cnt3_q    <= '0;
      en_q      <= 1'b0;
      tcs_q     <= 1'b0;
      al_q      <= 1'b0;
      fl_q      <= 1'b0;
      tc2_q     <= 1'b0;
      upd_q     <= 1'b0;
      dack_q    <= 1'b0;
      busrq_n_q <= 1'b1;
    end else begin
      phase_q   <= phase_d;
      adr2_q    <= adr2_d;
      cnt2_q    <= cnt2_d;
      adr3_q    <= adr3_d;
      cnt3_q    <= cnt3_d;
      en_q      <= en_d;
      tcs_q     <= tcs_d;
      al_q      <= al_d;
      fl_q      <= fl_d;
      tc2_q     <= tc2_d;
      upd_q     <= upd_d;
      dack_q    <= dack_d;
      busrq_n_q <= busrq_n_d;
    end
  end

  always_comb begin
    io_dout = '0;
    if (in_rng) begin
      unique case (off)
        4'd0: io_dout = fl_q ? adr2_q[15:8] : adr2_q[7:0];
        4'd1: io_dout = fl_q ? cnt2_q[15:8] : cnt2_q[7:0];
        4'd2: io_dout = fl_q ? adr3_q[15:8] : adr3_q[7:0];
        4'd3: io_dout = fl_q ? cnt3_q[15:8] : cnt3_q[7:0];
        4'd4: io_dout = {3'b000, upd_q, 1'b0, tc2_q, 2'b00};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_8257.sv
// Directed bench for dmac_8257: register access, block transfer, autoload, abort, TC-stop, reset.
module tb_dmac_8257;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_we = 1'b0, io_re = 1'b0;
  logic [3:0]  io_adr = '0;
  logic [7:0]  io_din = '0;
  logic [7:0]  io_dout;
  logic        dreq = 1'b0;
  logic        busak_hold = 1'b0;
  logic        dack, z80_busrq_n, z80_busak_n, tc;
  logic [15:0] ram_adr;

  int unsigned n_chk = 0, n_err = 0;
  int unsigned bytes;
  logic [15:0] adr_tc;
  logic        seen;

  always #5 clk = ~clk;

  // Z80 grants the bus as soon as it is requested unless the bench withholds it.
  assign z80_busak_n = z80_busrq_n | busak_hold;

  dmac_8257 #(.XFER_CYC(2), .IO_BASE(4'h4)) dut (
    .clk(clk), .reset_n(reset_n), .io_we(io_we), .io_re(io_re), .io_adr(io_adr),
    .io_din(io_din), .io_dout(io_dout), .dreq(dreq), .dack(dack),
    .z80_busrq_n(z80_busrq_n), .z80_busak_n(z80_busak_n), .ram_adr(ram_adr), .tc(tc)
  );

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    io_adr = a; io_din = d; io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    @(negedge clk);
    io_adr = a; io_re = 1'b1;
    #1 d = io_dout;
    chk_w(tag, {8'h00, d}, {8'h00, exp});
    @(negedge clk);
    io_re = 1'b0;
  endtask

  task automatic wait_dack();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dack) break;
    end
    chk_b("dack_grant", dack, 1'b1);
  endtask

  // Counts completed bytes (address steps + the tc byte) and flags any non-unit step.
  task automatic wait_tc(input int unsigned budget, output int unsigned nbytes,
                         output logic [15:0] adr_at, output logic got);
    logic [15:0] last;
    int unsigned bad;
    last = ram_adr; nbytes = 0; bad = 0; got = 1'b0; adr_at = '0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ram_adr != last) begin
        if (ram_adr != last + 16'd1) bad++;
        nbytes++;
        last = ram_adr;
      end
      if (tc) begin
        got = 1'b1; adr_at = ram_adr; nbytes++;
        break;
      end
    end
    chk_b("tc_seen", got, 1'b1);
    chk_w("addr_steps_bad", 16'(bad), 16'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_b("rst_dack", dack, 1'b0);
    chk_b("rst_busrq_n", z80_busrq_n, 1'b1);
    chk_b("rst_tc", tc, 1'b0);
    chk_w("rst_ram_adr", ram_adr, 16'h0000);
    reset_n = 1'b1;
    rd_chk("rst_adr2_lo", 4'h4, 8'h00);
    rd_chk("rst_adr2_hi", 4'h4, 8'h00);
    rd_chk("rst_stat", 4'h8, 8'h00);

    // Plain block of 120 bytes, then status read-clear
    wr(4'h4, 8'h00); wr(4'h4, 8'h30); wr(4'h5, 8'h77); wr(4'h5, 8'h00); wr(4'h8, 8'h04);
    chk_w("t1_start_adr", ram_adr, 16'h3000);
    dreq = 1'b1;
    @(negedge clk);
    chk_b("t1_busrq_lat", z80_busrq_n, 1'b0);
    chk_b("t1_dack_not_yet", dack, 1'b0);
    @(negedge clk);
    chk_b("t1_dack_lat", dack, 1'b1);
    wait_tc(400, bytes, adr_tc, seen);
    chk_w("t1_tc_adr", adr_tc, 16'h3077);
    chk_w("t1_bytes", 16'(bytes), 16'd120);
    @(negedge clk);
    chk_b("t1_tc_pulse", tc, 1'b0);
    chk_w("t1_adr_after", ram_adr, 16'h3078);
    dreq = 1'b0;
    @(negedge clk);
    chk_b("t1_rel_busrq", z80_busrq_n, 1'b1);
    chk_b("t1_rel_dack", dack, 1'b0);
    rd_chk("t4_stat_tc", 4'h8, 8'h04);
    rd_chk("t4_stat_clr", 4'h8, 8'h00);
    rd_chk("t1_cnt_wrap_lo", 4'h5, 8'hFF);
    rd_chk("t1_cnt_wrap_hi", 4'h5, 8'h3F);

    // Autoload
    wr(4'h8, 8'h84);
    wr(4'h4, 8'h00); wr(4'h4, 8'h30); wr(4'h5, 8'h77); wr(4'h5, 8'h00);
    rd_chk("t2_adr3_lo", 4'h6, 8'h00);
    rd_chk("t2_adr3_hi", 4'h6, 8'h30);
    rd_chk("t2_cnt3_lo", 4'h7, 8'h77);
    rd_chk("t2_cnt3_hi", 4'h7, 8'h00);
    dreq = 1'b1;
    wait_dack();
    wait_tc(400, bytes, adr_tc, seen);
    chk_w("t2_tc_adr", adr_tc, 16'h3077);
    @(negedge clk);
    chk_w("t2_reload_adr", ram_adr, 16'h3000);
    io_adr = 4'h8; io_re = 1'b1;
    #1 chk_w("t2_stat_upd", {8'h00, io_dout}, 16'h0014);
    @(negedge clk);
    io_re = 1'b0;
    chk_w("t2_first_byte", ram_adr, 16'h3000);
    @(negedge clk);
    chk_w("t2_second_byte", ram_adr, 16'h3001);
    io_adr = 4'h8; io_re = 1'b1;
    #1 chk_w("t2_stat_upd_clr", {8'h00, io_dout}, 16'h0000);
    @(negedge clk);
    io_re = 1'b0; dreq = 1'b0;
    rd_chk("t2_adr3_lo_post", 4'h6, 8'h00);
    rd_chk("t2_adr3_hi_post", 4'h6, 8'h30);
    rd_chk("t2_cnt3_lo_post", 4'h7, 8'h77);
    rd_chk("t2_cnt3_hi_post", 4'h7, 8'h00);

    // dreq drops after 10 bytes, then resumes
    wr(4'h8, 8'h04);
    wr(4'h4, 8'h00); wr(4'h4, 8'h30); wr(4'h5, 8'h77); wr(4'h5, 8'h00);
    dreq = 1'b1;
    wait_dack();
    for (int i = 0; i < 60; i++) begin
      if (ram_adr == 16'h300A) break;
      @(negedge clk);
    end
    chk_w("t3_stop_adr", ram_adr, 16'h300A);
    dreq = 1'b0;
    @(negedge clk);
    chk_b("t3_busrq_rel", z80_busrq_n, 1'b1);
    chk_b("t3_dack_rel", dack, 1'b0);
    rd_chk("t3_cnt_lo", 4'h5, 8'h6D);
    rd_chk("t3_cnt_hi", 4'h5, 8'h00);
    rd_chk("t3_adr_lo", 4'h4, 8'h0A);
    rd_chk("t3_adr_hi", 4'h4, 8'h30);
    dreq = 1'b1;
    wait_dack();
    chk_w("t3_resume_adr", ram_adr, 16'h300A);
    repeat (2) @(negedge clk);
    chk_w("t3_resume_step", ram_adr, 16'h300B);
    dreq = 1'b0;
    repeat (2) @(negedge clk);

    // Request withdrawn before the bus is granted
    busak_hold = 1'b1; dreq = 1'b1;
    @(negedge clk);
    chk_b("abort_busrq", z80_busrq_n, 1'b0);
    @(negedge clk);
    chk_b("abort_no_dack", dack, 1'b0);
    dreq = 1'b0;
    @(negedge clk);
    chk_b("abort_busrq_rel", z80_busrq_n, 1'b1);
    busak_hold = 1'b0;

    // TC-stop with address wrap FFFF -> 0000
    wr(4'h8, 8'h44);
    wr(4'h4, 8'hFF); wr(4'h4, 8'hFF); wr(4'h5, 8'h01); wr(4'h5, 8'h00);
    dreq = 1'b1;
    wait_dack();
    wait_tc(20, bytes, adr_tc, seen);
    chk_w("stop_tc_adr", adr_tc, 16'h0000);
    chk_w("stop_bytes", 16'(bytes), 16'd2);
    repeat (3) @(negedge clk);
    chk_b("stop_dack", dack, 1'b0);
    chk_b("stop_busrq", z80_busrq_n, 1'b1);
    chk_w("stop_adr", ram_adr, 16'h0001);
    dreq = 1'b0;
    rd_chk("stop_stat", 4'h8, 8'h04);

    // FL cleared by a mode write
    wr(4'h4, 8'h55); wr(4'h8, 8'h00); wr(4'h4, 8'h12); wr(4'h4, 8'h34);
    chk_w("t6_adr", ram_adr, 16'h3412);
    rd_chk("t6_rd_lo", 4'h4, 8'h12);
    rd_chk("t6_rd_hi", 4'h4, 8'h34);

    // Asynchronous reset during ACT
    wr(4'h8, 8'h04);
    dreq = 1'b1;
    wait_dack();
    repeat (3) @(negedge clk);
    chk_b("t5_dack_before", dack, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_b("t5_dack_async", dack, 1'b0);
    chk_b("t5_busrq_async", z80_busrq_n, 1'b1);
    chk_w("t5_adr_async", ram_adr, 16'h0000);
    dreq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("t5_adr2_lo", 4'h4, 8'h00);
    rd_chk("t5_adr2_hi", 4'h4, 8'h00);
    rd_chk("t5_cnt2_lo", 4'h5, 8'h00);
    rd_chk("t5_cnt2_hi", 4'h5, 8'h00);
    rd_chk("t5_adr3_lo", 4'h6, 8'h00);
    rd_chk("t5_adr3_hi", 4'h6, 8'h00);
    rd_chk("t5_cnt3_lo", 4'h7, 8'h00);
    rd_chk("t5_cnt3_hi", 4'h7, 8'h00);
    rd_chk("t5_stat", 4'h8, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
